alu_cmd_issue: RTL and testbench
================================

# alu_cmd_issue

Command buffer and issue stage directly upstream of the signed ALU function units (arithmetic, logic, compare, shift). Accepts {function, operand A, operand B} commands over a valid/ready handshake, queues them in a small FIFO, and issues at most one per clock as registered operands, a one-hot unit enable and a 2-bit sub-function. The compare unit, and its siblings, consume these outputs on the following clock edge.

## Interface

Parameters:
- in_width, 16, operand width (signed two's complement)
- depth, 4, FIFO entries (power of two, ≥2)
- cnt_width, 3, width of fill count (must hold 0..depth)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept this cycle
- cmd_func  input  4  [3:2] unit select, [1:0] sub-function
- cmd_a  input  in_width  signed operand A
- cmd_b  input  in_width  signed operand B
- issue_hold  input  1  freeze issue (FIFO still accepts)
- a  output  in_width  registered operand A to units
- b  output  in_width  registered operand B to units
- arith_enable, logic_enable, cmp_enable, shift_enable  output  1 each  one-hot unit enable
- alu_func  output  2  sub-function to selected unit
- issue_valid  output  1  high when one enable is high
- fifo_count  output  cnt_width  entries currently queued

## Operation

- Push: cmd_valid && cmd_ready at a rising edge writes entry at wr_ptr; wr_ptr wraps modulo depth.
- cmd_ready = (fifo_count != depth); combinational from count only, not from pop. Push at full never occurs even with simultaneous pop.
- Pop/issue: when fifo_count != 0 and !issue_hold, head entry popped; rd_ptr wraps modulo depth.
- Decode of cmd_func[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift; exactly one enable set on issue. alu_func = cmd_func[1:0].
- Issue cycle: a, b, alu_func, enable, issue_valid all registered from head entry.
- Non-issue cycle (empty or hold): all four enables and issue_valid = 0; a, b, alu_func hold last issued values.
- Simultaneous push and pop: fifo_count unchanged; pointers both advance.
- FIFO order strictly preserved; no reordering, no dropping.
- Reset (any cycle, including mid-stream): pointers and fifo_count to 0, queued commands discarded.

## Timing

- Reset values: a=0, b=0, alu_func=0, all enables 0, issue_valid=0, fifo_count=0, cmd_ready=1 after reset edge.
- Base latency (macro off): command accepted at edge N appears on outputs after edge N+1 (if no hold and it is at head).
- Throughput: one command per clock sustained when !issue_hold.
- issue_hold asserted at edge N: outputs after N show enables 0; queue retained; first issue after deassertion at next edge.
- Downstream units register their result one edge after issue, so result appears after edge N+2 (macro off).
- fifo_count reflects post-edge state; counts 0..depth inclusive.

## Configuration

- ALU_CMD_BYPASS_EN defined: when fifo_count == 0, !issue_hold and cmd_valid at edge N, the command is written directly to the output registers at edge N (latency 1) and not stored; fifo_count stays 0. When FIFO non-empty, normal path (order preserved).
- ALU_CMD_BYPASS_EN undefined: every command passes through the FIFO; latency always ≥2 edges; no bypass logic present.

## Test plan

- Reset then single push func=4'b1001 (cmp, >), a=5, b=-3 -> after edge N+1 (N+0 with bypass): cmp_enable=1, alu_func=01... corrected: alu_func=2'b01, a=5, b=-3, issue_valid=1; next cycle enables 0, a/b held.
- Hold asserted, push 4 commands (func 0000, 0101, 1010, 1111) -> cmd_ready=0 at fifo_count=4, no enables; release hold -> arith, logic, cmp, shift enables in that order on 4 consecutive cycles with alu_func 00,01,10,11.
- Full FIFO, cmd_valid=1 with hold off -> no push that cycle, count 4→3, cmd_ready=1 next cycle; push accepted after; no loss, order intact.
- Continuous push every cycle for 20 commands, no hold -> 20 issues, fifo_count constant (1 without bypass, 0 with bypass), pointers wrap past depth correctly.
- rst asserted with 3 queued and one issuing -> after reset edge all outputs 0, fifo_count=0, cmd_ready=1; none of the queued commands issue afterward.

Source files
------------

// File: rtl/alu_cmd_issue_if.sv
// Command and issue bundle between the command source, alu_cmd_issue, and the ALU units.
// master drives commands and reads the issue outputs; slave is the issue stage itself.
interface alu_cmd_issue_if #(
  parameter int in_width  = 16,
  parameter int cnt_width = 3
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [3:0]                 cmd_func;
  logic signed [in_width-1:0] cmd_a;
  logic signed [in_width-1:0] cmd_b;
  logic                       issue_hold;
  logic signed [in_width-1:0] a;
  logic signed [in_width-1:0] b;
  logic                       arith_enable;
  logic                       logic_enable;
  logic                       cmp_enable;
  logic                       shift_enable;
  logic [1:0]                 alu_func;
  logic                       issue_valid;
  logic [cnt_width-1:0]       fifo_count;

  modport master (
    output cmd_valid, cmd_func, cmd_a, cmd_b, issue_hold,
    input  cmd_ready, a, b, arith_enable, logic_enable, cmp_enable, shift_enable,
           alu_func, issue_valid, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_func, cmd_a, cmd_b, issue_hold,
    output cmd_ready, a, b, arith_enable, logic_enable, cmp_enable, shift_enable,
           alu_func, issue_valid, fifo_count
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// Command FIFO and registered issue stage feeding the ALU function units.
// Optional ALU_CMD_BYPASS_EN: an empty, unheld queue forwards an incoming command straight to the outputs.
module alu_cmd_issue #(
  parameter int in_width  = 16,
  parameter int depth     = 4,
  parameter int cnt_width = 3
) (
  input  logic           clk,
  input  logic           rst,
  alu_cmd_issue_if.slave bus
);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;

  typedef struct packed {
    logic [3:0]                 func;
    logic signed [in_width-1:0] a;
    logic signed [in_width-1:0] b;
  } cmd_t;

  cmd_t                       mem [depth];
  cmd_t                       in_cmd;
  cmd_t                       src;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [cnt_width-1:0]       count;
  logic                       push, pop, wr, go;
  logic signed [in_width-1:0] a_q, b_q;
  logic [1:0]                 func_q;
  logic [3:0]                 en;
  logic                       vld;

  assign in_cmd        = '{func: bus.cmd_func, a: bus.cmd_a, b: bus.cmd_b};
  assign bus.cmd_ready = (count != cnt_width'(depth));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (count != '0) && !bus.issue_hold;

`ifdef ALU_CMD_BYPASS_EN
  logic byp;
  // Bypass only when the queue is empty, so it can never overtake a queued command.
  assign byp = (count == '0) && !bus.issue_hold && bus.cmd_valid;
  assign wr  = push && !byp;
  assign go  = pop || byp;
  always_comb begin
    src = mem[rd_ptr];
    if (byp) src = in_cmd;
  end
`else
  assign wr  = push;
  assign go  = pop;
  assign src = mem[rd_ptr];
`endif

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (wr && !pop)      count <= count + cnt_width'(1);
      else if (!wr && pop) count <= count - cnt_width'(1);
    end
  end

  // Operands and sub-function keep their last issued values on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      func_q <= '0;
      en     <= '0;
      vld    <= 1'b0;
    end else if (go) begin
      a_q    <= src.a;
      b_q    <= src.b;
      func_q <= src.func[1:0];
      en     <= 4'b0001 << src.func[3:2];
      vld    <= 1'b1;
    end else begin
      en     <= '0;
      vld    <= 1'b0;
    end
  end

  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.alu_func     = func_q;
  assign bus.arith_enable = en[0];
  assign bus.logic_enable = en[1];
  assign bus.cmp_enable   = en[2];
  assign bus.shift_enable = en[3];
  assign bus.issue_valid  = vld;
  assign bus.fifo_count   = count;
endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: queue-based reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_alu_cmd_issue;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_cmd_issue_if #(.in_width(W), .cnt_width(CW)) bus();
  alu_cmd_issue #(.in_width(W), .depth(D), .cnt_width(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]          func;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
  } cmd_s;

  cmd_s                q[$];
  logic signed [W-1:0] m_a = '0;
  logic signed [W-1:0] m_b = '0;
  logic [1:0]          m_func = '0;
  int                  m_unit = -1;
  bit                  m_live = 1'b0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a command queue with the spec's accept/issue rules.
  always @(posedge clk) begin
    cmd_s c;
    cmd_s h;
    bit   acc;
    bit   byp;
    c = '{bus.cmd_func, bus.cmd_a, bus.cmd_b};
    if (rst) begin
      q.delete();
      m_a = '0; m_b = '0; m_func = '0; m_unit = -1;
      m_live = 1'b1;
    end else begin
      acc = bus.cmd_valid && (q.size() < D);
      byp = 1'b0;
`ifdef ALU_CMD_BYPASS_EN
      byp = bus.cmd_valid && (q.size() == 0) && !bus.issue_hold;
`endif
      if (q.size() > 0 && !bus.issue_hold) begin
        h = q.pop_front();
        m_a = h.a; m_b = h.b; m_func = h.func[1:0]; m_unit = int'(h.func[3:2]);
      end else if (byp) begin
        m_a = c.a; m_b = c.b; m_func = c.func[1:0]; m_unit = int'(c.func[3:2]);
      end else begin
        m_unit = -1;
      end
      if (acc && !byp) q.push_back(c);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("a",           bus.a,            m_a);
      chk("b",           bus.b,            m_b);
      chk("alu_func",    bus.alu_func,     m_func);
      chk("arith_en",    bus.arith_enable, m_unit == 0);
      chk("logic_en",    bus.logic_enable, m_unit == 1);
      chk("cmp_en",      bus.cmp_enable,   m_unit == 2);
      chk("shift_en",    bus.shift_enable, m_unit == 3);
      chk("issue_valid", bus.issue_valid,  m_unit >= 0);
      chk("fifo_count",  bus.fifo_count,   q.size());
      chk("cmd_ready",   bus.cmd_ready,    q.size() != D);
    end
  end

  task automatic step(input bit v, input logic [3:0] f, input int av, input int bv, input bit h);
    bus.cmd_valid  = v;
    bus.cmd_func   = f;
    bus.cmd_a      = W'(av);
    bus.cmd_b      = W'(bv);
    bus.issue_hold = h;
    @(negedge clk);
  endtask

  task automatic idle(input bit h);
    step(1'b0, 4'b0000, 0, 0, h);
  endtask

  initial begin
    int nis;
    logic [3:0] en_v;
    idle(0);
    idle(0);
    rst = 1'b0;
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_valid", bus.issue_valid, 0);
    chk("rst_a", bus.a, 0);

    // Single compare command
    step(1'b1, 4'b1001, 5, -3, 0);
`ifndef ALU_CMD_BYPASS_EN
    chk("t1_wait_valid", bus.issue_valid, 0);
    chk("t1_wait_count", bus.fifo_count, 1);
    idle(0);
`endif
    chk("t1_cmp_en", bus.cmp_enable, 1);
    chk("t1_func", bus.alu_func, 1);
    chk("t1_a", bus.a, 5);
    chk("t1_b", bus.b, -3);
    chk("t1_valid", bus.issue_valid, 1);
    idle(0);
    chk("t1_idle_cmp", bus.cmp_enable, 0);
    chk("t1_idle_a", bus.a, 5);
    chk("t1_idle_b", bus.b, -3);

    // Fill under hold, then release: one unit per cycle in order
    step(1'b1, 4'b0000, 1, 11, 1);
    step(1'b1, 4'b0101, 2, 12, 1);
    step(1'b1, 4'b1010, 3, 13, 1);
    step(1'b1, 4'b1111, 4, 14, 1);
    chk("t2_full_count", bus.fifo_count, 4);
    chk("t2_full_ready", bus.cmd_ready, 0);
    chk("t2_hold_valid", bus.issue_valid, 0);
    for (int i = 0; i < 4; i++) begin
      idle(0);
      en_v = {bus.shift_enable, bus.cmp_enable, bus.logic_enable, bus.arith_enable};
      chk("t2_enables", en_v, 4'b0001 << i);
      chk("t2_func", bus.alu_func, i);
      chk("t2_a", bus.a, i + 1);
    end

    // Full FIFO with valid and no hold: rejected that cycle, no loss
    step(1'b1, 4'b0000, 10, 0, 1);
    step(1'b1, 4'b0000, 11, 0, 1);
    step(1'b1, 4'b0000, 12, 0, 1);
    step(1'b1, 4'b0000, 13, 0, 1);
    step(1'b1, 4'b0110, 14, 0, 0);
    chk("t3_count", bus.fifo_count, 3);
    chk("t3_ready", bus.cmd_ready, 1);
    chk("t3_a", bus.a, 10);
    step(1'b1, 4'b0110, 14, 0, 0);
    chk("t3_count2", bus.fifo_count, 3);
    chk("t3_a2", bus.a, 11);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      chk("t3_drain_a", bus.a, 12 + i);
    end
    chk("t3_last_func", bus.alu_func, 2'b10);
    chk("t3_empty", bus.fifo_count, 0);

    // Continuous stream of 20 commands, pointers wrap several times
    nis = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'(i), 100 + i, -i, 0);
      nis += int'(bus.issue_valid);
`ifdef ALU_CMD_BYPASS_EN
      chk("t4_count", bus.fifo_count, 0);
      chk("t4_a", bus.a, 100 + i);
`else
      chk("t4_count", bus.fifo_count, 1);
      if (i > 0) chk("t4_a", bus.a, 100 + i - 1);
`endif
    end
    idle(0);
    nis += int'(bus.issue_valid);
    chk("t4_issues", nis, 20);
    chk("t4_last_a", bus.a, 119);
    chk("t4_last_b", bus.b, -19);

    // Reset mid-stream with queued commands
    step(1'b1, 4'b0001, 200, 0, 1);
    step(1'b1, 4'b0010, 201, 0, 1);
    step(1'b1, 4'b0011, 202, 0, 1);
    step(1'b1, 4'b0100, 203, 0, 1);
    idle(0);
    chk("t5_issue_a", bus.a, 200);
    chk("t5_queued", bus.fifo_count, 3);
    rst = 1'b1;
    idle(0);
    rst = 1'b0;
    chk("t5_rst_a", bus.a, 0);
    chk("t5_rst_b", bus.b, 0);
    chk("t5_rst_func", bus.alu_func, 0);
    chk("t5_rst_valid", bus.issue_valid, 0);
    chk("t5_rst_count", bus.fifo_count, 0);
    chk("t5_rst_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      idle(0);
      chk("t5_no_issue", bus.issue_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
